// File: rtl/bright_spot_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bright_spot_tracker: per-frame statistics (count, bounding box, centroid  |
// | sums) of pixels at or above a threshold, read back via custom instruction |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module bright_spot_tracker #(
    parameter logic [7:0] customInstructionId = 8'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pixelWord,
    input  logic        pixelValid,
    input  logic        lineDone,
    input  logic        frameDone,
    input  logic        ciStart,
    input  logic        ciCke,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic [31:0] ciResult,
    output logic        ciDone
);

    localparam logic [10:0] COORD_MIN_INIT = 11'h7FF;
    localparam logic [10:0] LINE_Y_MAX     = 11'h7FF;
    localparam logic [7:0]  THRESHOLD_INIT = 8'd200;

    logic        is_my_ci;
    logic [2:0]  ci_cmd;
    logic        unused_ci_bits;

    logic [8:0]  word_cnt_q, word_cnt_d;
    logic [10:0] line_y_q, line_y_d;

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_word_q, s1_word_d;
    logic [10:0] s1_x_base_q, s1_x_base_d;
    logic [10:0] s1_y_q, s1_y_d;
    logic        s1_frame_done_q, s1_frame_done_d;

    logic [3:0]  s2_mask_q, s2_mask_d;
    logic [2:0]  s2_hits_q, s2_hits_d;
    logic [13:0] s2_x_sum_q, s2_x_sum_d;
    logic [10:0] s2_x_base_q, s2_x_base_d;
    logic [10:0] s2_y_q, s2_y_d;
    logic        s2_frame_done_q, s2_frame_done_d;

    logic [21:0] acc_count_q, acc_count_d, pub_count_q, pub_count_d;
    logic [31:0] acc_sum_x_q, acc_sum_x_d, pub_sum_x_q, pub_sum_x_d;
    logic [31:0] acc_sum_y_q, acc_sum_y_d, pub_sum_y_q, pub_sum_y_d;
    logic [10:0] acc_min_x_q, acc_min_x_d, pub_min_x_q, pub_min_x_d;
    logic [10:0] acc_max_x_q, acc_max_x_d, pub_max_x_q, pub_max_x_d;
    logic [10:0] acc_min_y_q, acc_min_y_d, pub_min_y_q, pub_min_y_d;
    logic [10:0] acc_max_y_q, acc_max_y_d, pub_max_y_q, pub_max_y_d;

    logic [7:0]  threshold_q, threshold_d;
    logic        enable_q, enable_d;
    logic        armed_q, armed_d;
    logic        frame_ready_q, frame_ready_d;

    logic [1:0]  hit_min_off, hit_max_off;
    logic [10:0] hit_min_x, hit_max_x;
    logic        has_hit;
    logic [22:0] count_sum;
    logic [13:0] y_prod;
    logic [21:0] upd_count;
    logic [31:0] upd_sum_x, upd_sum_y;
    logic [10:0] upd_min_x, upd_max_x, upd_min_y, upd_max_y;

    assign is_my_ci       = ciStart & ciCke & (ciN == customInstructionId);
    assign ci_cmd         = ciValueA[2:0];
    assign ciDone         = is_my_ci;
    assign unused_ci_bits = ^{ciValueA[31:3], ciValueB[31:9]};

    // Position counters; a word arriving with lineDone/frameDone still uses the old x/y.
    always_comb begin
        word_cnt_d = word_cnt_q;
        line_y_d   = line_y_q;
        if (lineDone || frameDone) begin
            word_cnt_d = 9'd0;
        end else if (pixelValid) begin
            word_cnt_d = word_cnt_q + 9'd1;
        end
        if (frameDone) begin
            line_y_d = 11'd0;
        end else if (lineDone && (line_y_q != LINE_Y_MAX)) begin
            line_y_d = line_y_q + 11'd1;
        end
    end

    always_comb begin
        s1_valid_d      = pixelValid;
        s1_word_d       = pixelWord;
        s1_x_base_d     = {word_cnt_q, 2'b00};
        s1_y_d          = line_y_q;
        s1_frame_done_d = frameDone;
    end

    // Pixel k sits at byte 3-k, so the leftmost pixel gets the lowest x.
    always_comb begin
        s2_mask_d       = 4'd0;
        s2_hits_d       = 3'd0;
        s2_x_sum_d      = 14'd0;
        s2_x_base_d     = s1_x_base_q;
        s2_y_d          = s1_y_q;
        s2_frame_done_d = s1_frame_done_q;
        for (int k = 0; k < 4; k++) begin
            s2_mask_d[k] = s1_valid_q && (s1_word_q[8*(3-k) +: 8] >= threshold_q);
            if (s2_mask_d[k]) begin
                s2_hits_d  = s2_hits_d + 3'd1;
                s2_x_sum_d = s2_x_sum_d + {3'd0, s1_x_base_q} + 14'(k);
            end
        end
    end

    always_comb begin
        hit_min_off = 2'd0;
        hit_max_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (s2_mask_q[k]) hit_min_off = 2'(k);
        end
        for (int k = 0; k < 4; k++) begin
            if (s2_mask_q[k]) hit_max_off = 2'(k);
        end
        hit_min_x = s2_x_base_q + {9'd0, hit_min_off};
        hit_max_x = s2_x_base_q + {9'd0, hit_max_off};
        has_hit   = |s2_mask_q;
        count_sum = {1'b0, acc_count_q} + {20'd0, s2_hits_q};
        upd_count = count_sum[22] ? '1 : count_sum[21:0];
        upd_sum_x = acc_sum_x_q + {18'd0, s2_x_sum_q};
        y_prod    = {11'd0, s2_hits_q} * {3'd0, s2_y_q};
        upd_sum_y = acc_sum_y_q + {18'd0, y_prod};
        upd_min_x = (has_hit && (hit_min_x < acc_min_x_q)) ? hit_min_x : acc_min_x_q;
        upd_max_x = (has_hit && (hit_max_x > acc_max_x_q)) ? hit_max_x : acc_max_x_q;
        upd_min_y = (has_hit && (s2_y_q < acc_min_y_q)) ? s2_y_q : acc_min_y_q;
        upd_max_y = (has_hit && (s2_y_q > acc_max_y_q)) ? s2_y_q : acc_max_y_q;
    end

    // The word riding with the delayed frameDone is folded into the published snapshot.
    always_comb begin
        acc_count_d   = upd_count;
        acc_sum_x_d   = upd_sum_x;
        acc_sum_y_d   = upd_sum_y;
        acc_min_x_d   = upd_min_x;
        acc_max_x_d   = upd_max_x;
        acc_min_y_d   = upd_min_y;
        acc_max_y_d   = upd_max_y;
        pub_count_d   = pub_count_q;
        pub_sum_x_d   = pub_sum_x_q;
        pub_sum_y_d   = pub_sum_y_q;
        pub_min_x_d   = pub_min_x_q;
        pub_max_x_d   = pub_max_x_q;
        pub_min_y_d   = pub_min_y_q;
        pub_max_y_d   = pub_max_y_q;
        armed_d       = armed_q;
        frame_ready_d = frame_ready_q;
        if (!armed_q || s2_frame_done_q) begin
            acc_count_d = 22'd0;
            acc_sum_x_d = 32'd0;
            acc_sum_y_d = 32'd0;
            acc_min_x_d = COORD_MIN_INIT;
            acc_max_x_d = 11'd0;
            acc_min_y_d = COORD_MIN_INIT;
            acc_max_y_d = 11'd0;
        end
        if (is_my_ci && (ci_cmd == 3'd7)) frame_ready_d = 1'b0;
        if (s2_frame_done_q) begin
            armed_d = enable_q;
            if (armed_q) begin
                pub_count_d   = upd_count;
                pub_sum_x_d   = upd_sum_x;
                pub_sum_y_d   = upd_sum_y;
                pub_min_x_d   = upd_min_x;
                pub_max_x_d   = upd_max_x;
                pub_min_y_d   = upd_min_y;
                pub_max_y_d   = upd_max_y;
                frame_ready_d = 1'b1;
            end
        end
    end

    always_comb begin
        threshold_d = threshold_q;
        enable_d    = enable_q;
        if (is_my_ci && (ci_cmd == 3'd5)) begin
            threshold_d = ciValueB[7:0];
            enable_d    = ciValueB[8];
        end
    end

    always_comb begin
        ciResult = 32'd0;
        if (is_my_ci) begin
            case (ci_cmd)
                3'd0:    ciResult = {10'd0, pub_count_q};
                3'd1:    ciResult = {5'd0, pub_max_x_q, 5'd0, pub_min_x_q};
                3'd2:    ciResult = {5'd0, pub_max_y_q, 5'd0, pub_min_y_q};
                3'd3:    ciResult = pub_sum_x_q;
                3'd4:    ciResult = pub_sum_y_q;
                3'd6:    ciResult = {23'd0, enable_q, threshold_q};
                3'd7:    ciResult = {31'd0, frame_ready_q};
                default: ciResult = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            word_cnt_q      <= 9'd0;
            line_y_q        <= 11'd0;
            s1_valid_q      <= 1'b0;
            s1_word_q       <= 32'd0;
            s1_x_base_q     <= 11'd0;
            s1_y_q          <= 11'd0;
            s1_frame_done_q <= 1'b0;
            s2_mask_q       <= 4'd0;
            s2_hits_q       <= 3'd0;
            s2_x_sum_q      <= 14'd0;
            s2_x_base_q     <= 11'd0;
            s2_y_q          <= 11'd0;
            s2_frame_done_q <= 1'b0;
            acc_count_q     <= 22'd0;
            acc_sum_x_q     <= 32'd0;
            acc_sum_y_q     <= 32'd0;
            acc_min_x_q     <= COORD_MIN_INIT;
            acc_max_x_q     <= 11'd0;
            acc_min_y_q     <= COORD_MIN_INIT;
            acc_max_y_q     <= 11'd0;
            pub_count_q     <= 22'd0;
            pub_sum_x_q     <= 32'd0;
            pub_sum_y_q     <= 32'd0;
            pub_min_x_q     <= 11'd0;
            pub_max_x_q     <= 11'd0;
            pub_min_y_q     <= 11'd0;
            pub_max_y_q     <= 11'd0;
            threshold_q     <= THRESHOLD_INIT;
            enable_q        <= 1'b0;
            armed_q         <= 1'b0;
            frame_ready_q   <= 1'b0;
        end else begin
            word_cnt_q      <= word_cnt_d;
            line_y_q        <= line_y_d;
            s1_valid_q      <= s1_valid_d;
            s1_word_q       <= s1_word_d;
            s1_x_base_q     <= s1_x_base_d;
            s1_y_q          <= s1_y_d;
            s1_frame_done_q <= s1_frame_done_d;
            s2_mask_q       <= s2_mask_d;
            s2_hits_q       <= s2_hits_d;
            s2_x_sum_q      <= s2_x_sum_d;
            s2_x_base_q     <= s2_x_base_d;
            s2_y_q          <= s2_y_d;
            s2_frame_done_q <= s2_frame_done_d;
            acc_count_q     <= acc_count_d;
            acc_sum_x_q     <= acc_sum_x_d;
            acc_sum_y_q     <= acc_sum_y_d;
            acc_min_x_q     <= acc_min_x_d;
            acc_max_x_q     <= acc_max_x_d;
            acc_min_y_q     <= acc_min_y_d;
            acc_max_y_q     <= acc_max_y_d;
            pub_count_q     <= pub_count_d;
            pub_sum_x_q     <= pub_sum_x_d;
            pub_sum_y_q     <= pub_sum_y_d;
            pub_min_x_q     <= pub_min_x_d;
            pub_max_x_q     <= pub_max_x_d;
            pub_min_y_q     <= pub_min_y_d;
            pub_max_y_q     <= pub_max_y_d;
            threshold_q     <= threshold_d;
            enable_q        <= enable_d;
            armed_q         <= armed_d;
            frame_ready_q   <= frame_ready_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bright_spot_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bright_spot_tracker: directed and randomized frames against a         |
// | pixel-list reference model of bright_spot_tracker                        |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_bright_spot_tracker;

    localparam logic [7:0] CI_ID = 8'h2A;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pixelWord = '0;
    logic        pixelValid = 1'b0;
    logic        lineDone = 1'b0;
    logic        frameDone = 1'b0;
    logic        ciStart = 1'b0;
    logic        ciCke = 1'b0;
    logic [7:0]  ciN = '0;
    logic [31:0] ciValueA = '0;
    logic [31:0] ciValueB = '0;
    logic [31:0] ciResult;
    logic        ciDone;

    bright_spot_tracker #(.customInstructionId(CI_ID)) dut (
        .clock(clock), .reset(reset), .pixelWord(pixelWord), .pixelValid(pixelValid),
        .lineDone(lineDone), .frameDone(frameDone), .ciStart(ciStart), .ciCke(ciCke),
        .ciN(ciN), .ciValueA(ciValueA), .ciValueB(ciValueB),
        .ciResult(ciResult), .ciDone(ciDone)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bright pixel coordinates of the current frame, reduced at frame end.
    int          m_wcnt, m_y, m_armed, m_en, m_ready;
    logic [7:0]  m_thr;
    int          q_x[$];
    int          q_y[$];
    logic [31:0] p_count, p_sum_x, p_sum_y, p_min_x, p_max_x, p_min_y, p_max_y;
    logic [31:0] got;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_wcnt = 0; m_y = 0; m_armed = 0; m_en = 0; m_ready = 0; m_thr = 8'd200;
        q_x.delete(); q_y.delete();
        p_count = 0; p_sum_x = 0; p_sum_y = 0;
        p_min_x = 0; p_max_x = 0; p_min_y = 0; p_max_y = 0;
    endtask

    task automatic model_publish();
        p_count = (q_x.size() > 32'h3FFFFF) ? 32'h3FFFFF : 32'(q_x.size());
        p_sum_x = 0; p_sum_y = 0;
        p_min_x = 2047; p_max_x = 0; p_min_y = 2047; p_max_y = 0;
        foreach (q_x[i]) begin
            p_sum_x = p_sum_x + 32'(q_x[i]);
            p_sum_y = p_sum_y + 32'(q_y[i]);
            if (q_x[i] < int'(p_min_x)) p_min_x = 32'(q_x[i]);
            if (q_x[i] > int'(p_max_x)) p_max_x = 32'(q_x[i]);
            if (q_y[i] < int'(p_min_y)) p_min_y = 32'(q_y[i]);
            if (q_y[i] > int'(p_max_y)) p_max_y = 32'(q_y[i]);
        end
        m_ready = 1;
        q_x.delete(); q_y.delete();
    endtask

    task automatic model_step(input bit v, input logic [31:0] w, input bit ld, input bit fd);
        logic [7:0] pix;
        if (v && m_armed != 0) begin
            for (int k = 0; k < 4; k++) begin
                pix = 8'((w >> (8 * (3 - k))) & 32'hFF);
                if (pix >= m_thr) begin
                    q_x.push_back(4 * m_wcnt + k);
                    q_y.push_back(m_y);
                end
            end
        end
        if (fd) begin
            if (m_armed != 0) model_publish();
            m_armed = m_en;
            m_wcnt = 0; m_y = 0;
        end else if (ld) begin
            m_wcnt = 0;
            if (m_y < 2047) m_y++;
        end else if (v) begin
            m_wcnt = (m_wcnt + 1) % 512;
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] w, input bit ld, input bit fd,
                         input bit cs, input bit ck, input logic [7:0] n,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        pixelValid = v; pixelWord = w; lineDone = ld; frameDone = fd;
        ciStart = cs; ciCke = ck; ciN = n; ciValueA = a; ciValueB = b;
        model_step(v, w, ld, fd);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, '0, 0, 0, 0, 0, 8'd0, '0, '0);
    endtask

    task automatic word_in(input logic [31:0] w, input bit ld, input bit fd);
        drive(1, w, ld, fd, 0, 0, 8'd0, '0, '0);
    endtask

    task automatic pulse(input bit ld, input bit fd);
        drive(0, '0, ld, fd, 0, 0, 8'd0, '0, '0);
    endtask

    task automatic ci_op(input string tag, input int cmd, input logic [31:0] b,
                         output logic [31:0] res);
        logic [31:0] exp;
        drive(0, '0, 0, 0, 1, 1, CI_ID, 32'(cmd), b);
        #1;
        res = ciResult;
        exp = 32'd0;
        case (cmd)
            0: exp = p_count;
            1: exp = {5'd0, p_max_x[10:0], 5'd0, p_min_x[10:0]};
            2: exp = {5'd0, p_max_y[10:0], 5'd0, p_min_y[10:0]};
            3: exp = p_sum_x;
            4: exp = p_sum_y;
            5: begin exp = 32'd0; m_thr = b[7:0]; m_en = int'(b[8]); end
            6: exp = {23'd0, m_en[0], m_thr};
            7: begin exp = 32'(m_ready); m_ready = 0; end
            default: exp = 32'd0;
        endcase
        check_eq({tag, "_done"}, 32'(ciDone), 32'd1);
        check_eq(tag, res, exp);
    endtask

    task automatic read_all(input string tag);
        int cmds[7] = '{0, 1, 2, 3, 4, 6, 7};
        logic [31:0] r;
        idle(3);
        foreach (cmds[i]) ci_op($sformatf("%s_ci%0d", tag, cmds[i]), cmds[i], '0, r);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        pixelValid = 0; pixelWord = '0; lineDone = 0; frameDone = 0;
        ciStart = 0; ciCke = 0; ciN = '0; ciValueA = '0; ciValueB = '0;
        #1;
        check_eq("rst_ci_done", 32'(ciDone), 32'd0);
        check_eq("rst_ci_result", ciResult, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        int nl, nw, mode;
        model_reset();
        do_reset();

        // Reset state and CI decode.
        ci_op("init_cnt", 0, '0, got);   check_eq("init_cnt_c", got, 32'd0);
        ci_op("init_x", 1, '0, got);     check_eq("init_x_c", got, 32'd0);
        ci_op("init_thr", 6, '0, got);   check_eq("init_thr_c", got, 32'h000000C8);
        ci_op("init_rdy", 7, '0, got);   check_eq("init_rdy_c", got, 32'd0);
        drive(0, '0, 0, 0, 1, 1, CI_ID + 8'd1, 32'd6, '0);
        #1;
        check_eq("other_ci_done", 32'(ciDone), 32'd0);
        check_eq("other_ci_result", ciResult, 32'd0);
        drive(0, '0, 0, 0, 1, 0, CI_ID, 32'd6, '0);
        #1;
        check_eq("nocke_done", 32'(ciDone), 32'd0);
        check_eq("nocke_result", ciResult, 32'd0);

        // Single bright pixel in word 2 of line 1.
        ci_op("wr180", 5, 32'h180, got);
        pulse(0, 1); idle(3);
        repeat (4) word_in(32'h0, 0, 0);
        pulse(1, 0);
        word_in(32'h0, 0, 0); word_in(32'h0, 0, 0);
        word_in(32'h00FF0000, 0, 0); word_in(32'h0, 0, 0);
        pulse(1, 0); pulse(0, 1);
        read_all("one_px");
        ci_op("one_px_rdy2", 7, '0, got);  check_eq("one_px_rdy2_c", got, 32'd0);
        ci_op("one_px_cnt", 0, '0, got);   check_eq("one_px_cnt_c", got, 32'd1);
        ci_op("one_px_x", 1, '0, got);     check_eq("one_px_x_c", got, 32'h00090009);
        ci_op("one_px_y", 2, '0, got);     check_eq("one_px_y_c", got, 32'h00010001);
        ci_op("one_px_sx", 3, '0, got);    check_eq("one_px_sx_c", got, 32'd9);
        ci_op("one_px_sy", 4, '0, got);    check_eq("one_px_sy_c", got, 32'd1);

        // Threshold boundary: 0x7F misses, 0x80/0x81 hit.
        word_in(32'h7F808180, 0, 0); pulse(0, 1);
        read_all("thr");
        ci_op("thr_cnt", 0, '0, got);  check_eq("thr_cnt_c", got, 32'd3);
        ci_op("thr_sx", 3, '0, got);   check_eq("thr_sx_c", got, 32'd6);
        ci_op("thr_x", 1, '0, got);    check_eq("thr_x_c", got, 32'h00030001);

        // Last word arrives together with frameDone.
        word_in(32'h7F808180, 0, 0); word_in(32'hFF000000, 0, 1);
        read_all("last_word");
        ci_op("lw_cnt", 0, '0, got);   check_eq("lw_cnt_c", got, 32'd4);
        ci_op("lw_x", 1, '0, got);     check_eq("lw_x_c", got, 32'h00040001);
        ci_op("lw_sx", 3, '0, got);    check_eq("lw_sx_c", got, 32'd10);

        // Empty frame, then frameDone set racing a CI 7 clear.
        word_in(32'h01020304, 0, 0); pulse(0, 1);
        read_all("empty");
        ci_op("empty_cnt", 0, '0, got);  check_eq("empty_cnt_c", got, 32'd0);
        ci_op("empty_x", 1, '0, got);    check_eq("empty_x_c", got, 32'h000007FF);
        pulse(0, 1); idle(1);
        drive(0, '0, 0, 0, 1, 1, CI_ID, 32'd7, '0);
        #1;
        check_eq("prio_same_cycle", ciResult, 32'd0);
        idle(3);
        ci_op("prio_after", 7, '0, got); check_eq("prio_after_c", got, 32'd1);

        // Word counter wrap and line saturation.
        repeat (511) word_in(32'h0, 0, 0);
        word_in(32'h000000FF, 0, 0); word_in(32'hFF000000, 0, 0);
        pulse(0, 1);
        read_all("wrap");
        ci_op("wrap_x", 1, '0, got);  check_eq("wrap_x_c", got, 32'h07FF0000);
        repeat (2050) pulse(1, 0);
        word_in(32'h000000FF, 0, 0); pulse(0, 1);
        read_all("ysat");
        ci_op("ysat_y", 2, '0, got);  check_eq("ysat_y_c", got, 32'h07FF07FF);
        ci_op("ysat_sy", 4, '0, got); check_eq("ysat_sy_c", got, 32'd2047);

        // Enable raised mid-frame must not publish that frame.
        ci_op("dis", 5, 32'h080, got);
        pulse(0, 1);
        read_all("dis");
        word_in(32'hFFFFFFFF, 0, 0);
        ci_op("en_mid", 5, 32'h180, got);
        word_in(32'hFFFFFFFF, 0, 0); pulse(0, 1);
        read_all("partial");
        ci_op("partial_rdy", 7, '0, got); check_eq("partial_rdy_c", got, 32'd0);
        word_in(32'h000000FF, 0, 0); pulse(0, 1);
        read_all("full");
        ci_op("full_cnt", 0, '0, got);  check_eq("full_cnt_c", got, 32'd1);
        ci_op("full_x", 1, '0, got);    check_eq("full_x_c", got, 32'h00030003);

        // Reset in the middle of a frame.
        word_in(32'hFFFFFFFF, 0, 0); word_in(32'hFFFFFFFF, 0, 0);
        do_reset();
        read_all("mid_rst");
        ci_op("mr_cnt", 0, '0, got);  check_eq("mr_cnt_c", got, 32'd0);
        ci_op("mr_x", 1, '0, got);    check_eq("mr_x_c", got, 32'd0);
        ci_op("mr_thr", 6, '0, got);  check_eq("mr_thr_c", got, 32'h000000C8);
        word_in(32'hFFFFFFFF, 0, 0); pulse(0, 1);
        word_in(32'hFFFFFFFF, 0, 0); pulse(0, 1);
        read_all("mr_noen");
        ci_op("mr_noen_cnt", 0, '0, got);  check_eq("mr_noen_cnt_c", got, 32'd0);
        ci_op("mr_en", 5, 32'h1C8, got);
        pulse(0, 1); idle(3);
        word_in(32'hFFFFFFFF, 0, 0); pulse(0, 1);
        read_all("mr_en");
        ci_op("mr_en_cnt", 0, '0, got);  check_eq("mr_en_cnt_c", got, 32'd4);

        // Randomized frames against the model.
        for (int f = 0; f < 24; f++) begin
            if (f == 0 || $urandom_range(0, 2) == 0)
                ci_op("rnd_wr", 5, {23'd0, ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255))}, got);
            nl = int'($urandom_range(1, 4));
            for (int l = 0; l < nl; l++) begin
                nw = int'($urandom_range(1, 8));
                for (int i = 0; i < nw; i++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    if (i < nw - 1) begin
                        word_in($urandom, 0, 0);
                    end else if (l < nl - 1) begin
                        if ($urandom_range(0, 1) == 0) word_in($urandom, 1, 0);
                        else begin word_in($urandom, 0, 0); pulse(1, 0); end
                    end else begin
                        mode = int'($urandom_range(0, 2));
                        if (mode == 0) word_in($urandom, 0, 1);
                        else if (mode == 1) begin word_in($urandom, 0, 0); pulse(0, 1); end
                        else begin word_in($urandom, 1, 0); pulse(0, 1); end
                    end
                end
            end
            read_all($sformatf("rnd%0d", f));
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bright_spot_tracker.md
BRIGHT_SPOT_TRACKER -- requirements
Module: bright_spot_tracker

Interface
REQ-001 SHALL have parameter customInstructionId, default 8'd0, the CI number this block answers.
REQ-002 SHALL have port clock  input  1  the single system clock; all logic is on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset, sampled on clock).
REQ-004 SHALL have port pixelWord  input  32  four 8-bit grey pixels; bits 31:24 = leftmost pixel, bits 7:0 = rightmost.
REQ-005 SHALL have port pixelValid  input  1  qualifies pixelWord for one cycle.
REQ-006 SHALL have port lineDone  input  1  one-cycle pulse marking the end of the current line.
REQ-007 SHALL have port frameDone  input  1  one-cycle pulse marking the end of the current frame.
REQ-008 SHALL have ports ciStart, ciCke  input  1 each  custom-instruction strobes.
REQ-009 SHALL have ports ciN  input  8 and ciValueA, ciValueB  input  32 each  CI selector and operands.
REQ-010 SHALL have ports ciResult  output  32 and ciDone  output  1  CI result and completion.

Function
REQ-011 SHALL decode isMyCi = ciStart & ciCke & (ciN == customInstructionId).
REQ-012 SHALL drive ciDone = isMyCi combinationally, in the same cycle.
REQ-013 SHALL drive ciResult = 0 whenever isMyCi = 0.
REQ-014 SHALL map the CI commands on ciValueA[2:0]:
  - 0: pixel count.
  - 1: {5'd0,maxX,5'd0,minX}.
  - 2: {5'd0,maxY,5'd0,minY}.
  - 3: sumX.
  - 4: sumY.
  - 5: write threshold = ciValueB[7:0], enable = ciValueB[8]; result 0.
  - 6: read {23'd0,enable,threshold}.
  - 7: read {31'd0,frameReady}, then clear frameReady.
REQ-015 SHALL count pixel x position with a 9-bit word counter: pixel k (0..3, left to right) of word w has x = 4*w+k. The counter increments on each pixelValid, wraps at 511, and clears on lineDone or frameDone.
REQ-016 SHALL hold line index y in 11 bits: +1 on lineDone, saturating at 2047; cleared on frameDone.
REQ-017 SHALL treat a pixel as bright when its value >= threshold (unsigned compare).
REQ-018 SHALL run a 3-stage pipeline:
  - S1 registers the word with its x base and y.
  - S2 registers a 4-bit hit mask, the hit count, and the hit x sum.
  - S3 updates the accumulators.
  lineDone and frameDone are delayed by the same 2 cycles so the last word of a line or frame is always counted.
REQ-019 SHALL, for each S3 update, apply:
  - count += hits, 22-bit, saturating at all ones.
  - sumX += sum of x over hits, 32-bit, wraps.
  - sumY += hits*y, 32-bit, wraps.
  - min/max X and min/max Y updated with the bright pixels only.
REQ-020 SHALL, when pixelValid and lineDone coincide, attribute the word to the current line before y advances.
REQ-021 SHALL, on delayed frameDone with the armed flag set, in a single cycle:
  - copy the accumulators into the published registers;
  - set frameReady;
  - reset the accumulators to count = 0, sums = 0, minX = minY = 11'h7FF, maxX = maxY = 0.
REQ-022 SHALL publish an empty frame (no bright pixels) as count 0, min 11'h7FF, max 0.
REQ-023 SHALL sample the enable bit into the armed flag only on delayed frameDone, so enabling mid-frame never publishes a partial frame.
REQ-024 SHALL, while armed = 0, keep the accumulators at reset values and leave the published registers unchanged.
REQ-025 SHALL give frameDone (set) priority over a simultaneous CI command 7 (clear); frameReady stays 1.
REQ-026 SHALL apply a threshold written mid-frame from the next S2 compare onwards.

Reset
REQ-027 SHALL, while reset = 0 at a rising clock edge, clear and hold:
  - pipeline and all counters;
  - accumulators to the values in REQ-021;
  - published registers to 0;
  - frameReady = 0, enable = 0, armed = 0, threshold = 8'd200.
REQ-028 SHALL be driven by isMyCi alone for ciDone/ciResult, so both are 0 during reset unless a CI is presented.

Verification
REQ-029 SHALL cover CI write 5 with B = 0x180, then one frame of two lines with pixelWord 0x00FF0000 at word 2 of line 1 -> count 1, minX = maxX = 9, minY = maxY = 1, sumX 9, sumY 1, frameReady 1; a second CI 7 read returns 0.
REQ-030 SHALL cover threshold 0x80, a word 0x7F808180 -> hits at k = 1,2,3; with w = 0, y = 0: count 3, sumX 6, minX 1, maxX 3.
REQ-031 SHALL cover enable set mid-frame -> no publish at that frameDone; the next full frame publishes.
REQ-032 SHALL cover an empty frame -> count 0, CI 1 returns 0x000007FF.
REQ-033 SHALL cover frameDone in the same cycle as pixelValid on the last word -> that word is counted.
REQ-034 SHALL cover reset = 0 mid-frame -> all reads 0 except threshold (CI 6 returns 0xC8), and later frames are not published until enable is written.
